spi_master_ctrl: RTL

- Host-side SPI master that drives the MOSI/SS_n/MISO pins of the SPI slave + RAM subsystem, all on the same system clock.
- Converts one host request (2-bit command + 8-bit payload) into one SPI frame.
- Commands: 00 write address, 01 write data, 10 read address, 11 read data.
- For read-data frames it captures the returned byte from MISO and presents it to the host with a one-cycle valid pulse.

---
 rtl/spi_master_ctrl_if.sv | 22 ++
 rtl/spi_master_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host request/response bundle for spi_master_ctrl
interface spi_master_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_payload;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  // Host side: issues requests, consumes responses.
  modport master (
    output req_valid, req_cmd, req_payload,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  // Controller side.
  modport slave (
    input  req_valid, req_cmd, req_payload,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master turning one host request into one SPI frame
module spi_master_ctrl #(
  parameter int READ_LAT = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_ctrl_if.slave   host,
  output logic               MOSI,
  output logic               SS_n,
  input  logic               MISO
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, RECV, GAP} state_t;

  // Last count value of the turnaround and inter-frame gap phases.
  localparam logic [3:0] TURN_LAST = 4'(READ_LAT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [9:0] frame_q, frame_d;
  logic       rd_q, rd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       mosi_q, mosi_d;
  logic       ss_n_q, ss_n_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  assign host.req_ready = (state_q == IDLE);
  assign host.busy      = (state_q != IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign MOSI           = mosi_q;
  assign SS_n           = ss_n_q;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    mosi_d      = mosi_q;
    ss_n_d      = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        if (host.req_valid) begin
          frame_d = {host.req_cmd, host.req_payload};
          rd_d    = (host.req_cmd == 2'b11);
          ss_n_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        // Frame register shifts left so bit 9 is always the next bit out.
        mosi_d  = frame_q[9];
        frame_d = {frame_q[8:0], 1'b0};
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == 4'd9) begin
          mosi_d = 1'b0;
          cnt_d  = 4'd0;
          if (rd_q) begin
            state_d = TURN;
          end else begin
            ss_n_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          mosi_d  = frame_q[9];
          frame_d = {frame_q[8:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
        end
      end
      TURN: begin
        // The edge closing the last turnaround cycle is the first MISO sample.
        if (cnt_q == TURN_LAST) begin
          shift_d = {shift_q[6:0], MISO};
          cnt_d   = 4'd1;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECV: begin
        shift_d = {shift_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          rsp_data_d  = {shift_q[6:0], MISO};
          rsp_valid_d = 1'b1;
          ss_n_d      = 1'b1;
          cnt_d       = 4'd0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        mosi_d  = 1'b0;
        ss_n_d  = 1'b1;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops SS_n high at once, abandoning any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= 10'd0;
      rd_q        <= 1'b0;
      cnt_q       <= 4'd0;
      shift_q     <= 8'd0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
